// File: rtl/egg_timer.sv
// egg_timer: kitchen egg timer controller.
// The user sets an MM:SS cook time with the minute and second buttons, then
// starts a one-second-resolution countdown to 00:00. Drives four BCD digits
// for the display multiplexer, the FSM state code and a running flag.
module egg_timer #(
    parameter int CLKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       cook_time,
    input  logic       minutes,
    input  logic       seconds,
    output logic       seconds_out,
    output logic       minutes_out,
    output logic [2:0] m_tens,
    output logic [3:0] m_ones,
    output logic [2:0] s_tens,
    output logic [3:0] s_ones,
    output logic [2:0] z,
    output logic       timer_enabled
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Displayed time as four BCD digits, most significant first.
    typedef struct packed {
        logic [2:0] m_tens;
        logic [3:0] m_ones;
        logic [2:0] s_tens;
        logic [3:0] s_ones;
    } bcd_time_t;

    localparam int TICK_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_SEC - 1);

    state_t            state;
    bcd_time_t         cur;
    logic [TICK_W-1:0] tick;
    logic              sec_q;
    logic              min_q;
    logic              sec_edge;
    logic              min_edge;
    logic              time_zero;
    logic              time_one;

    // Increment a two-digit BCD field 00..59, wrapping 59 -> 00.
    function automatic logic [6:0] inc_field(input logic [6:0] f);
        logic [6:0] r;
        r = f;
        if (f[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[6:4] = (f[6:4] == 3'd5) ? 3'd0 : f[6:4] + 3'd1;
        end else begin
            r[3:0] = f[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Subtract one second with BCD borrow; 00:00 stays at 00:00.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t != '0) begin
            if (t.s_ones != 4'd0) begin
                r.s_ones = t.s_ones - 4'd1;
            end else begin
                r.s_ones = 4'd9;
                if (t.s_tens != 3'd0) begin
                    r.s_tens = t.s_tens - 3'd1;
                end else begin
                    r.s_tens = 3'd5;
                    if (t.m_ones != 4'd0) begin
                        r.m_ones = t.m_ones - 4'd1;
                    end else begin
                        r.m_ones = 4'd9;
                        r.m_tens = t.m_tens - 3'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    assign sec_edge  = seconds & ~sec_q;
    assign min_edge  = minutes & ~min_q;
    assign time_zero = (cur == '0);
    assign time_one  = (cur == bcd_time_t'(14'd1));

    assign z      = state;
    assign m_tens = cur.m_tens;
    assign m_ones = cur.m_ones;
    assign s_tens = cur.s_tens;
    assign s_ones = cur.s_ones;

    // Button history: one register per button so a held press is one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q <= 1'b0;
            min_q <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples the pre-edge values regardless of statement order.
            sec_q <= seconds;
            min_q <= minutes;
        end
    end

    // Controller FSM with registered time, tick counter, pulses and run flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cur           <= '0;
            tick          <= '0;
            seconds_out   <= 1'b0;
            minutes_out   <= 1'b0;
            timer_enabled <= 1'b0;
        end else begin
            // NOTE: pulses and the run flag default low every cycle; each branch
            // below only raises them, so no path can leave a stale value behind.
            seconds_out   <= 1'b0;
            minutes_out   <= 1'b0;
            timer_enabled <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cur   <= '0;
                tick  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cur <= '0;
                        if (cook_time) state <= SET;
                    end
                    SET: begin
                        if (sec_edge) begin
                            {cur.s_tens, cur.s_ones} <= inc_field({cur.s_tens, cur.s_ones});
                            seconds_out <= 1'b1;
                        end
                        if (min_edge) begin
                            {cur.m_tens, cur.m_ones} <= inc_field({cur.m_tens, cur.m_ones});
                            minutes_out <= 1'b1;
                        end
                        if (!cook_time) state <= READY;
                    end
                    READY: begin
                        if (cook_time) begin
                            state <= SET;
                        end else if (start && !time_zero) begin
                            state         <= RUN;
                            tick          <= '0;
                            timer_enabled <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!start) begin
                            state <= PAUSE;
                        end else if (tick == TICK_LAST) begin
                            tick <= '0;
                            cur  <= dec_time(cur);
                            if (time_one) state <= DONE;
                            else          timer_enabled <= 1'b1;
                        end else begin
                            tick          <= tick + 1'b1;
                            timer_enabled <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state         <= RUN;
                            timer_enabled <= 1'b1;
                        end else if (cook_time) begin
                            state <= SET;
                        end
                    end
                    DONE: begin
                        if (cook_time) state <= SET;
                    end
                    default: begin
                        state <= IDLE;
                        cur   <= '0;
                        tick  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_egg_timer.sv
// tb_egg_timer: directed and randomized checks of egg_timer against a
// reference model that tracks the set time as plain integer minutes/seconds
// and the countdown as elapsed run cycles divided by the tick period.
module tb_egg_timer;

    localparam int CPS = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic       cook_time;
    logic       minutes;
    logic       seconds;
    logic       seconds_out;
    logic       minutes_out;
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
    logic [2:0] z;
    logic       timer_enabled;

    int errors = 0;
    int checks = 0;
    int mm = 0;
    int ss = 0;

    egg_timer #(.CLKS_PER_SEC(CPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .cook_time    (cook_time),
        .minutes      (minutes),
        .seconds      (seconds),
        .seconds_out  (seconds_out),
        .minutes_out  (minutes_out),
        .m_tens       (m_tens),
        .m_ones       (m_ones),
        .s_tens       (s_tens),
        .s_ones       (s_ones),
        .z            (z),
        .timer_enabled(timer_enabled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Digits compared as a decimal MMSS number, e.g. 02:03 -> 203.
    task automatic check_time(input string tag, input int m, input int s);
        check(tag, 32'(m_tens) * 1000 + 32'(m_ones) * 100 + 32'(s_tens) * 10 + 32'(s_ones),
              32'(m * 100 + s));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press in SET: hold the button(s), release, count pulses, update the model.
    task automatic press(input bit ps, input bit pm, input int hold);
        logic [31:0] sc;
        logic [31:0] mc;
        sc = 0;
        mc = 0;
        seconds = ps;
        minutes = pm;
        repeat (hold) begin
            step(1);
            sc = sc + 32'(seconds_out);
            mc = mc + 32'(minutes_out);
        end
        seconds = 1'b0;
        minutes = 1'b0;
        step(1);
        sc = sc + 32'(seconds_out);
        mc = mc + 32'(minutes_out);
        if (ps) ss = (ss + 1) % 60;
        if (pm) mm = (mm + 1) % 60;
        check("sec_pulse_count", sc, ps ? 1 : 0);
        check("min_pulse_count", mc, pm ? 1 : 0);
        check_time("set_time", mm, ss);
    endtask

    task automatic set_to(input int m, input int s);
        int nm;
        int ns;
        nm = (m - mm + 60) % 60;
        ns = (s - ss + 60) % 60;
        repeat (nm) press(1'b0, 1'b1, $urandom_range(1, 3));
        repeat (ns) press(1'b1, 1'b0, $urandom_range(1, 3));
    endtask

    initial begin
        int total;
        int k;
        int r;
        reset     = 1'b0;
        enable    = 1'b0;
        start     = 1'b0;
        cook_time = 1'b0;
        minutes   = 1'b0;
        seconds   = 1'b0;

        // Reset state
        step(3);
        check("rst_z", z, 0);
        check_time("rst_time", 0, 0);
        check("rst_te", timer_enabled, 0);
        check("rst_pulses", {seconds_out, minutes_out}, 0);

        // Released reset with enable low stays IDLE
        reset = 1'b1;
        step(3);
        check("idle_disabled_z", z, 0);

        // Enter SET
        enable    = 1'b1;
        cook_time = 1'b1;
        step(1);
        check("enter_set_z", z, 1);
        check("set_te", timer_enabled, 0);

        // Three second presses, two minute presses, each held several cycles
        repeat (3) press(1'b1, 1'b0, 4);
        repeat (2) press(1'b0, 1'b1, 4);
        check_time("set_0203", 2, 3);

        // Random presses including simultaneous ones
        repeat (12) begin
            r = $urandom_range(0, 2);
            press(r != 1, r != 0, $urandom_range(1, 4));
        end

        // Seconds wrap 59 -> 00 with no carry into minutes
        set_to(0, 59);
        check_time("at_0059", 0, 59);
        press(1'b1, 1'b0, 2);
        check_time("sec_wrap", 0, 0);

        // READY at 00:00 ignores start
        cook_time = 1'b0;
        step(1);
        check("ready_z", z, 2);
        start = 1'b1;
        step(5);
        check("ready_zero_start_z", z, 2);
        check("ready_zero_start_te", timer_enabled, 0);
        start     = 1'b0;
        cook_time = 1'b1;
        step(1);
        check("ready_to_set_z", z, 1);

        // Minutes wrap 59 -> 00 keeps seconds
        set_to(59, 5);
        press(1'b0, 1'b1, 2);
        check_time("min_wrap", 0, 5);

        // Countdown from 01:01 with random button/cook_time noise
        set_to(1, 1);
        cook_time = 1'b0;
        step(1);
        check("cd_ready_z", z, 2);
        start = 1'b1;
        step(1);
        check("cd_run_z", z, 3);
        check("cd_run_te", timer_enabled, 1);
        check_time("cd_start", 1, 1);
        total = 61;
        for (int i = 1; i <= 243; i++) begin
            seconds   = 1'($urandom_range(0, 1));
            minutes   = 1'($urandom_range(0, 1));
            cook_time = 1'($urandom_range(0, 1));
            step(1);
            r = total - i / CPS;
            check_time("cd_time", r / 60, r % 60);
            check("cd_z", z, 3);
            check("cd_pulses", {seconds_out, minutes_out}, 0);
        end
        seconds   = 1'b0;
        minutes   = 1'b0;
        cook_time = 1'b0;
        step(1);
        check_time("cd_zero", 0, 0);
        check("cd_done_z", z, 5);
        check("cd_done_te", timer_enabled, 0);
        step(3);
        check("done_hold_z", z, 5);
        check_time("done_hold_time", 0, 0);

        // DONE -> SET, random nonzero time, then pause/resume
        cook_time = 1'b1;
        step(1);
        check("done_to_set_z", z, 1);
        mm = 0;
        ss = 0;
        set_to($urandom_range(1, 3), $urandom_range(0, 59));
        total = mm * 60 + ss;
        cook_time = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("pr_run_z", z, 3);
        k = 0;
        r = $urandom_range(5, 20);
        repeat (r) begin
            step(1);
            k++;
            check_time("pr_run_time", (total - k / CPS) / 60, (total - k / CPS) % 60);
        end
        start = 1'b0;
        step(1);
        check("pause_z", z, 4);
        check("pause_te", timer_enabled, 0);
        repeat (10) begin
            step(1);
            check("pause_hold_z", z, 4);
            check_time("pause_hold_time", (total - k / CPS) / 60, (total - k / CPS) % 60);
        end
        start = 1'b1;
        step(1);
        check("resume_z", z, 3);
        check("resume_te", timer_enabled, 1);
        check_time("resume_time", (total - k / CPS) / 60, (total - k / CPS) % 60);
        repeat (8) begin
            step(1);
            k++;
            check_time("resume_count", (total - k / CPS) / 60, (total - k / CPS) % 60);
            check("resume_run_z", z, 3);
        end

        // enable low during RUN clears everything on the next edge
        enable = 1'b0;
        step(1);
        check("disable_z", z, 0);
        check_time("disable_time", 0, 0);
        check("disable_te", timer_enabled, 0);
        mm = 0;
        ss = 0;

        // Asynchronous reset in the middle of a count
        enable    = 1'b1;
        cook_time = 1'b1;
        start     = 1'b0;
        step(1);
        check("re_set_z", z, 1);
        repeat (3) press(1'b1, 1'b0, 2);
        cook_time = 1'b0;
        step(1);
        start = 1'b1;
        step(3);
        check("pre_reset_z", z, 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_z", z, 0);
        check_time("async_rst_time", 0, 0);
        check("async_rst_te", timer_enabled, 0);
        enable = 1'b0;
        start  = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        check("post_rst_z", z, 0);
        check_time("post_rst_time", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/egg_timer.md
Name: egg_timer

Overview:
- Kitchen egg timer controller: user sets a cook time in MM:SS with minute and second push-buttons, then starts a one-second-resolution countdown to 00:00.
- Outputs BCD digits for a 4-digit 7-segment driver, the FSM state code, and status flags.
- Sits between the debounced board buttons and the display multiplexer.
- Single clock domain.

Parameters:
- CLKS_PER_SEC, 50_000_000, clock cycles per one-second tick. Benches override with a small value, e.g. 4.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 0 forces IDLE and clears the time.
- start  in  1  level; 1 runs the countdown, 0 pauses it.
- cook_time  in  1  level; 1 requests set mode.
- minutes  in  1  minute button; synchronous, debounced.
- seconds  in  1  second button; synchronous, debounced.
- seconds_out  out  1  one-cycle pulse when the seconds field is incremented in SET.
- minutes_out  out  1  one-cycle pulse when the minutes field is incremented in SET.
- m_tens  out  3  minutes tens BCD, 0-5.
- m_ones  out  4  minutes ones BCD, 0-9.
- s_tens  out  3  seconds tens BCD, 0-5.
- s_ones  out  4  seconds ones BCD, 0-9.
- z  out  3  current FSM state code.
- timer_enabled  out  1  high only in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; all digits 0.
  - seconds_out=0, minutes_out=0, timer_enabled=0.
  - tick counter 0; button history registers 0.
- Edge detect: each button is registered once. An edge is a cycle where the input is 1 and the registered value is 0. Holding a button gives a single edge.
- States and z codes:
  - IDLE=0, SET=1, READY=2, RUN=3, PAUSE=4, DONE=5. Codes 6-7 are unused and recover to IDLE.
- enable=0: next clock goes to IDLE and clears all digits. This has priority over every other transition.
- IDLE:
  - Digits held at 0.
  - enable=1 and cook_time=1 -> SET.
- SET:
  - Seconds edge: seconds field increments 00..59 and wraps 59->00 with no carry into minutes; seconds_out pulses in the same cycle.
  - Minutes edge: minutes field increments 00..59 and wraps 59->00; minutes_out pulses.
  - Both edges in the same cycle: both fields increment and both pulses are asserted.
  - cook_time=0 -> READY.
- READY:
  - Time held.
  - cook_time=1 -> SET.
  - start=1 with time nonzero -> RUN.
  - start=1 with time 00:00 -> stay in READY.
- RUN:
  - Tick counter is cleared on entry, counts 0..CLKS_PER_SEC-1, and wraps.
  - On wrap the time decrements by one second with BCD borrow: s_ones 0->9 borrows s_tens; s_tens 0->5 borrows m_ones; m_ones 0->9 borrows m_tens.
  - When the decrement yields 00:00 the state moves to DONE on the same clock edge.
  - start=0 -> PAUSE. The tick counter holds its value and the time is held.
  - cook_time and the buttons are ignored.
- PAUSE:
  - start=1 -> RUN, resuming the tick count from the held value.
  - cook_time=1 -> SET.
- DONE:
  - Holds 00:00.
  - cook_time=1 -> SET.
  - Otherwise stays until enable=0.
- Output timing:
  - All outputs are registered, except z, which is the state register itself.
  - A digit change is visible one cycle after the triggering sampled edge or tick wrap.
- Time never goes below 00:00. The maximum value is 59:59.

Test Plan:
- Reset check: hold reset=0 mid-count -> digits immediately 0, z=0, timer_enabled=0. Release reset -> stays IDLE while enable=0.
- Set mode: enable=1, cook_time=1 -> z=1. Pulse seconds 3 times and minutes 2 times (each held several cycles) -> display 02:03, and seconds_out/minutes_out each pulse exactly once per press.
- Wrap: from 00:59 in SET, press seconds -> 00:00 with minutes unchanged. From 59:xx, press minutes -> 00:xx.
- Countdown with CLKS_PER_SEC=4, time 01:01:
  - cook_time=0 -> z=2; start=1 -> z=3, timer_enabled=1.
  - After 4 cycles -> 01:00; after 4 more -> 00:59.
  - Time reaches 00:00 exactly 61x4 cycles after entering RUN, and z becomes 5 on the same edge.
- Pause/resume: in RUN drop start for 10 cycles -> z=4 and time frozen. Raise start -> z=3, and the next decrement occurs only after the remaining tick count elapses.
- Guards:
  - start=1 in READY at 00:00 -> stays z=2.
  - enable=0 during RUN -> next cycle z=0 and digits 0.
  - Buttons pressed during RUN -> no digit change and no seconds_out/minutes_out pulses.
